// File: rtl/video_port_ctrl.sv
// CPU-side video register port: decodes I/O writes into scroll/border/mode controls,
// a PPI-style port C latch, and a delayed, fixed-width palette write strobe.
module video_port_ctrl #(
   parameter int unsigned PAL_DELAY = 6,
   parameter int unsigned PAL_WIDTH = 4
) (
   input  logic       clk_24m,
   input  logic       reset,
   input  logic [7:0] io_addr,
   input  logic [7:0] io_dout,
   input  logic       io_wr,
   input  logic       io_rd,
   output logic [7:0] io_din,
   output logic [7:0] scroll,
   output logic [3:0] border,
   output logic       mode512,
   output logic [7:0] port_c,
   output logic [7:0] pal_data,
   output logic       pal_we,
   output logic       pal_busy,
   output logic [1:0] pal_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STROBE = 2'd2
   } pal_state_e;

   localparam logic [7:0] ADDR_CTRL  = 8'h00;
   localparam logic [7:0] ADDR_PORTC = 8'h01;
   localparam logic [7:0] ADDR_PORTB = 8'h02;
   localparam logic [7:0] ADDR_PORTA = 8'h03;
   localparam logic [7:0] ADDR_PAL   = 8'h0C;

   localparam logic [3:0] DELAY_LOAD = 4'(PAL_DELAY - 1);
   localparam logic [3:0] WIDTH_LOAD = 4'(PAL_WIDTH - 1);

   logic [7:0] scroll_q, scroll_d;
   logic [3:0] border_q, border_d;
   logic       mode512_q, mode512_d;
   logic [7:0] port_c_q, port_c_d;
   logic [7:0] io_din_q;
   logic [7:0] rd_data;

   pal_state_e state_q;
   logic [3:0] cnt_q;
   logic [7:0] pend_q;
   logic       pend_vld_q;
   logic [7:0] pal_data_q;
   logic       pal_we_q;

   logic wr_ctrl, wr_portc, wr_portb, wr_porta, wr_pal;

   assign wr_ctrl  = io_wr && (io_addr == ADDR_CTRL);
   assign wr_portc = io_wr && (io_addr == ADDR_PORTC);
   assign wr_portb = io_wr && (io_addr == ADDR_PORTB);
   assign wr_porta = io_wr && (io_addr == ADDR_PORTA);
   assign wr_pal   = io_wr && (io_addr == ADDR_PAL);

   // Control port: bit7 is a mode set clearing everything, else a single port C bit set/reset.
   always_comb begin
      scroll_d  = scroll_q;
      border_d  = border_q;
      mode512_d = mode512_q;
      port_c_d  = port_c_q;
      if (wr_ctrl) begin
         if (io_dout[7]) begin
            scroll_d  = 8'h00;
            border_d  = 4'h0;
            mode512_d = 1'b0;
            port_c_d  = 8'h00;
         end else begin
            port_c_d[io_dout[3:1]] = io_dout[0];
         end
      end
      if (wr_portc) port_c_d = io_dout;
      if (wr_portb) begin
         border_d  = io_dout[3:0];
         mode512_d = io_dout[4];
      end
      if (wr_porta) scroll_d = io_dout;
   end

   // Readback uses the registers before any same-cycle write lands.
   always_comb begin
      rd_data = 8'hFF;
      case (io_addr)
         ADDR_PORTC: rd_data = port_c_q;
         ADDR_PORTB: rd_data = {3'b000, mode512_q, border_q};
         ADDR_PORTA: rd_data = scroll_q;
         ADDR_PAL:   rd_data = pal_data_q;
         default:    rd_data = 8'hFF;
      endcase
   end

   always_ff @(posedge clk_24m) begin
      if (reset) begin
         scroll_q  <= 8'hFF;
         border_q  <= 4'h0;
         mode512_q <= 1'b0;
         port_c_q  <= 8'h00;
         io_din_q  <= 8'h00;
      end else begin
         scroll_q  <= scroll_d;
         border_q  <= border_d;
         mode512_q <= mode512_d;
         port_c_q  <= port_c_d;
         if (io_rd) io_din_q <= rd_data;
      end
   end

   // Palette FSM: a write arriving mid-strobe is parked and replayed after the strobe ends.
   always_ff @(posedge clk_24m) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'h0;
         pend_q     <= 8'h00;
         pend_vld_q <= 1'b0;
         pal_data_q <= 8'h00;
         pal_we_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               pal_we_q <= 1'b0;
               if (wr_pal) begin
                  pend_q  <= io_dout;
                  cnt_q   <= DELAY_LOAD;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wr_pal) begin
                  pend_q <= io_dout;
                  cnt_q  <= DELAY_LOAD;
               end else if (cnt_q == 4'h0) begin
                  pal_data_q <= pend_q;
                  pal_we_q   <= 1'b1;
                  cnt_q      <= WIDTH_LOAD;
                  state_q    <= ST_STROBE;
               end else begin
                  cnt_q <= cnt_q - 4'h1;
               end
            end
            ST_STROBE: begin
               if (wr_pal) begin
                  pend_q     <= io_dout;
                  pend_vld_q <= 1'b1;
               end
               if (cnt_q == 4'h0) begin
                  pal_we_q   <= 1'b0;
                  pend_vld_q <= 1'b0;
                  if (pend_vld_q || wr_pal) begin
                     cnt_q   <= DELAY_LOAD;
                     state_q <= ST_WAIT;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'h1;
               end
            end
            default: begin
               pal_we_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign io_din    = io_din_q;
   assign scroll    = scroll_q;
   assign border    = border_q;
   assign mode512   = mode512_q;
   assign port_c    = port_c_q;
   assign pal_data  = pal_data_q;
   assign pal_we    = pal_we_q;
   assign pal_busy  = (state_q != ST_IDLE);
   assign pal_state = state_q;

endmodule

// File: tb/tb_video_port_ctrl.sv
// Bench for video_port_ctrl: directed scenarios then random traffic, checked every cycle
// against an edge-time model of the register file and palette strobe schedule.
module tb_video_port_ctrl;

   localparam int D = 6;
   localparam int W = 4;

   logic       clk_24m = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] io_addr = 8'h00;
   logic [7:0] io_dout = 8'h00;
   logic       io_wr = 1'b0;
   logic       io_rd = 1'b0;
   logic [7:0] io_din, scroll, port_c, pal_data;
   logic [3:0] border;
   logic       mode512, pal_we, pal_busy;
   logic [1:0] pal_state;

   video_port_ctrl #(.PAL_DELAY(D), .PAL_WIDTH(W)) dut (
      .clk_24m(clk_24m), .reset(reset), .io_addr(io_addr), .io_dout(io_dout),
      .io_wr(io_wr), .io_rd(io_rd), .io_din(io_din), .scroll(scroll),
      .border(border), .mode512(mode512), .port_c(port_c), .pal_data(pal_data),
      .pal_we(pal_we), .pal_busy(pal_busy), .pal_state(pal_state)
   );

   always #5 clk_24m = ~clk_24m;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: plain register values plus the palette schedule as edge numbers.
   logic [7:0] m_scroll, m_port_c, m_din, m_pal_data, m_next_data, m_q_data;
   logic [3:0] m_border;
   logic       m_mode;
   int         m_e = 0;
   int         m_rise = 0;
   bit         m_rise_vld = 0;
   bit         m_queued = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [7:0] a);
      case (a)
         8'h01:   return m_port_c;
         8'h02:   return {3'b000, m_mode, m_border};
         8'h03:   return m_scroll;
         8'h0C:   return m_pal_data;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic m_we();
      return m_rise_vld && (m_e >= m_rise) && (m_e < m_rise + W);
   endfunction

   function automatic logic m_busy();
      return m_rise_vld && (m_e < m_rise + W);
   endfunction

   task automatic model_edge(input bit rst, input bit wr, input bit rd,
                             input logic [7:0] a, input logic [7:0] d);
      bit strobing;
      m_e++;
      if (rst) begin
         m_scroll = 8'hFF; m_border = 4'h0; m_mode = 1'b0; m_port_c = 8'h00;
         m_din = 8'h00; m_pal_data = 8'h00; m_rise_vld = 0; m_queued = 0;
         return;
      end
      if (rd) m_din = m_read(a);
      if (wr) begin
         case (a)
            8'h00: begin
               if (d[7]) begin
                  m_scroll = 8'h00; m_border = 4'h0; m_mode = 1'b0; m_port_c = 8'h00;
               end else begin
                  m_port_c[d[3:1]] = d[0];
               end
            end
            8'h01: m_port_c = d;
            8'h02: begin m_border = d[3:0]; m_mode = d[4]; end
            8'h03: m_scroll = d;
            default: ;
         endcase
      end
      // Strobe occupies edges [rise, rise+W); a write is "during the strobe" if the
      // previous edge left the strobe high.
      strobing = m_rise_vld && (m_e >= m_rise + 1) && (m_e <= m_rise + W);
      if (wr && a == 8'h0C) begin
         if (strobing) begin
            m_queued = 1; m_q_data = d;
         end else begin
            m_rise = m_e + D; m_next_data = d; m_rise_vld = 1;
         end
      end
      if (strobing && m_e == m_rise + W && m_queued) begin
         m_rise = m_e + D; m_next_data = m_q_data; m_queued = 0;
      end
      if (m_rise_vld && m_e == m_rise) m_pal_data = m_next_data;
   endtask

   task automatic check_all();
      check("scroll", scroll, m_scroll);
      check("border", {4'h0, border}, {4'h0, m_border});
      check("mode512", {7'h0, mode512}, {7'h0, m_mode});
      check("port_c", port_c, m_port_c);
      check("io_din", io_din, m_din);
      check("pal_data", pal_data, m_pal_data);
      check("pal_we", {7'h0, pal_we}, {7'h0, m_we()});
      check("pal_busy", {7'h0, pal_busy}, {7'h0, m_busy()});
   endtask

   task automatic cycle(input bit rst, input bit wr, input bit rd,
                        input logic [7:0] a, input logic [7:0] d);
      @(negedge clk_24m);
      reset = rst; io_wr = wr; io_rd = rd; io_addr = a; io_dout = d;
      @(posedge clk_24m);
      model_edge(rst, wr, rd, a, d);
      #1;
      check_all();
   endtask

   task automatic idle();
      cycle(0, 0, 0, 8'h00, 8'h00);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int first, last, rises, k;
      logic prev;
      logic [7:0] addr_tab [6];
      addr_tab[0] = 8'h00; addr_tab[1] = 8'h01; addr_tab[2] = 8'h02;
      addr_tab[3] = 8'h03; addr_tab[4] = 8'h0C; addr_tab[5] = 8'h0C;

      cycle(1, 0, 0, 8'h00, 8'h00);
      cycle(1, 0, 0, 8'h00, 8'h00);

      // Scenario 1: reset readback, scroll write and readback.
      cycle(0, 0, 1, 8'h03, 8'h00);
      check("t1_din_reset", io_din, 8'hFF);
      cycle(0, 1, 0, 8'h03, 8'h5A);
      check("t1_scroll", scroll, 8'h5A);
      cycle(0, 0, 1, 8'h03, 8'h00);
      check("t1_din_scroll", io_din, 8'h5A);

      // Scenario 2: port B then mode set.
      cycle(0, 1, 0, 8'h02, 8'h1F);
      check("t2_border", {4'h0, border}, 8'h0F);
      check("t2_mode512", {7'h0, mode512}, 8'h01);
      cycle(0, 1, 0, 8'h00, 8'h80);
      check("t2_clear", {scroll[7:1], scroll[0] | border[0] | mode512}, 8'h00);

      // Scenario 3: port C bit set then bit reset of an already-clear bit.
      cycle(0, 1, 0, 8'h00, 8'h07);
      check("t3_set_bit3", port_c, 8'h08);
      cycle(0, 1, 0, 8'h00, 8'h02);
      check("t3_clr_bit1", port_c, 8'h08);

      // Same-cycle write and read returns the pre-write value.
      cycle(0, 1, 1, 8'h03, 8'hC3);
      check("rw_same_cycle", io_din, 8'h00);

      // Scenario 4: single palette write timing; cycle numbering counts the write as 0.
      cycle(0, 1, 0, 8'h0C, 8'h3C);
      first = -1; last = -1;
      for (int i = 1; i <= 12; i++) begin
         idle();
         if (pal_we) begin
            if (first < 0) first = i + 1;
            last = i + 1;
         end
      end
      check("t4_we_first", 8'(first), 8'd7);
      check("t4_we_last", 8'(last), 8'd10);
      check("t4_pal_data", pal_data, 8'h3C);

      // Scenario 5: rewrite while waiting -> one strobe with the later data.
      cycle(0, 1, 0, 8'h0C, 8'h11);
      idle();
      cycle(0, 1, 0, 8'h0C, 8'h22);
      cycle(0, 1, 0, 8'h02, 8'h05);
      first = -1; rises = 0; prev = 1'b0;
      for (int i = 2; i <= 14; i++) begin
         idle();
         if (pal_we && !prev) begin
            rises++;
            if (first < 0) first = i + 1;
         end
         prev = pal_we;
      end
      check("t5_rises", 8'(rises), 8'd1);
      check("t5_we_first", 8'(first), 8'd7);
      check("t5_pal_data", pal_data, 8'h22);

      // Scenario 6: write during strobe, gap, second strobe, reset mid-strobe.
      cycle(0, 1, 0, 8'h0C, 8'hAA);
      k = 0;
      while (!pal_we && k < 20) begin idle(); k++; end
      check("t6_aa_rise", {7'h0, pal_we}, 8'h01);
      idle();
      cycle(0, 1, 0, 8'h0C, 8'hBB);
      check("t6_aa_held", pal_data, 8'hAA);
      k = 0;
      while (pal_we && k < 20) begin idle(); k++; end
      check("t6_gap", {7'h0, pal_we}, 8'h00);
      k = 0;
      while (!pal_we && k < 30) begin idle(); k++; end
      check("t6_bb_rise", {7'h0, pal_we}, 8'h01);
      check("t6_bb_data", pal_data, 8'hBB);
      idle();
      cycle(1, 0, 0, 8'h00, 8'h00);
      check("t6_reset_we", {7'h0, pal_we}, 8'h00);
      check("t6_reset_busy", {7'h0, pal_busy}, 8'h00);
      check("t6_reset_scroll", scroll, 8'hFF);

      // Random traffic with rare resets.
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addr_tab[$urandom_range(0, 5)];
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 3,
               $urandom_range(0, 9) < 3, a, 8'($urandom));
      end
      idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
